// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: single-cycle writes, reads returned
// after READ_LAT edges, with a combinational stall while a read is in flight.
module dm_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dm_rd_i,
  input  logic                  dm_wr_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam bit         SINGLE   = (READ_LAT == 1);
  // WAIT spends READ_LAT-1 edges counting CNT_INIT down to 0 inclusive.
  localparam logic [3:0] CNT_INIT = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rvalid;
  logic                  r_err;
  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_conflict;
  logic                  w_complete;
  logic                  w_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rd_addr   = r_raddr;
    w_rd_req    = 1'b0;
    w_wr_req    = 1'b0;
    w_conflict  = 1'b0;
    w_complete  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_rd_req   = dm_rd_i && !dm_wr_i;
        w_wr_req   = dm_wr_i && !dm_rd_i;
        w_conflict = dm_rd_i && dm_wr_i;
        if (w_rd_req) begin
          if (SINGLE) begin
            w_complete = 1'b1;
            w_rd_addr  = addr_i;
          end else begin
            w_busy      = 1'b1;
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Request inputs are deliberately ignored here, writes included.
        w_busy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_raddr  <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_complete;
      r_err    <= w_conflict;
      if (w_rd_req) r_raddr <= addr_i;
      if (w_complete) r_rdata <= r_mem[w_rd_addr];
    end
  end

  // Array is not cleared by reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_req) r_mem[addr_i] <= wdata_i;
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign busy_o   = w_busy;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: four instances (READ_LAT 1..4) checked every cycle
// against a transaction-level model of memory contents and read timing.
module tb_dm_responder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_v   [N];
  logic        rd_v    [N];
  logic        wr_v    [N];
  logic [7:0]  addr_v  [N];
  logic [15:0] wdata_v [N];
  logic [15:0] rdata_v [N];
  logic        rvalid_v[N];
  logic        busy_v  [N];
  logic        err_v   [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    dm_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .READ_LAT(g + 1)) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .dm_rd_i (rd_v[g]),
      .dm_wr_i (wr_v[g]),
      .addr_i  (addr_v[g]),
      .wdata_i (wdata_v[g]),
      .rdata_o (rdata_v[g]),
      .rvalid_o(rvalid_v[g]),
      .busy_o  (busy_v[g]),
      .err_o   (err_v[g])
    );
  end

  // Reference model: memory image plus "read in flight, edges still to go".
  logic [15:0] mem_m  [N][256];
  bit          pend   [N];
  int          remain [N];
  logic [7:0]  paddr  [N];
  logic [15:0] e_rdata[N];
  bit          e_rvalid[N];
  bit          e_err  [N];
  bit          armed = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s lat=%0d observed=%h expected=%h", tag, k + 1, obs, exp);
    end
  endtask

  task automatic tick();
    int lat;
    #1;
    for (int k = 0; k < N; k++) begin
      lat = k + 1;
      if (armed) chk("busy", k, {15'd0, busy_v[k]}, {15'd0, pend[k] || (rd_v[k] && !wr_v[k] && lat > 1)});
      e_rvalid[k] = 1'b0;
      e_err[k]    = 1'b0;
      if (rst_v[k]) begin
        pend[k]    = 1'b0;
        e_rdata[k] = 16'h0000;
      end else if (pend[k]) begin
        remain[k]--;
        if (remain[k] == 0) begin
          pend[k]     = 1'b0;
          e_rvalid[k] = 1'b1;
          e_rdata[k]  = mem_m[k][paddr[k]];
        end
      end else if (rd_v[k] && wr_v[k]) begin
        e_err[k] = 1'b1;
      end else if (wr_v[k]) begin
        mem_m[k][addr_v[k]] = wdata_v[k];
      end else if (rd_v[k]) begin
        if (lat == 1) begin
          e_rvalid[k] = 1'b1;
          e_rdata[k]  = mem_m[k][addr_v[k]];
        end else begin
          pend[k]   = 1'b1;
          remain[k] = lat - 1;
          paddr[k]  = addr_v[k];
        end
      end
    end
    @(posedge clk);
    #1;
    armed = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("rvalid", k, {15'd0, rvalid_v[k]}, {15'd0, e_rvalid[k]});
      chk("err", k, {15'd0, err_v[k]}, {15'd0, e_err[k]});
      chk("rdata", k, rdata_v[k], e_rdata[k]);
    end
  endtask

  task automatic set_in(input int k, input logic rd, input logic wr, input logic [7:0] a, input logic [15:0] d);
    rd_v[k]    = rd;
    wr_v[k]    = wr;
    addr_v[k]  = a;
    wdata_v[k] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < N; k++) begin
      set_in(k, 1'b0, 1'b0, 8'h00, 16'h0000);
      rst_v[k] = 1'b0;
    end
  endtask

  task automatic write_all(input logic [7:0] a, input logic [15:0] d);
    for (int k = 0; k < N; k++) set_in(k, 1'b0, 1'b1, a, d);
    tick();
    idle_all();
  endtask

  task automatic idle_ticks(input int n);
    idle_all();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      pend[k]     = 1'b0;
      remain[k]   = 0;
      paddr[k]    = 8'h00;
      e_rdata[k]  = 16'h0000;
      e_rvalid[k] = 1'b0;
      e_err[k]    = 1'b0;
      for (int a = 0; a < 256; a++) mem_m[k][a] = 16'hxxxx;
    end
    idle_all();

    // Reset for two cycles, then a quiet cycle.
    for (int k = 0; k < N; k++) rst_v[k] = 1'b1;
    tick();
    tick();
    idle_ticks(1);

    // Preload a small working set plus the directed addresses.
    for (int a = 0; a < 16; a++) write_all(8'(a), 16'($urandom));
    write_all(8'h00, 16'h0001);
    write_all(8'hFF, 16'hFFFF);
    write_all(8'h05, 16'h5555);
    write_all(8'h07, 16'h0707);
    write_all(8'h40, 16'h1234);

    // Lat 2: write then read on the very next cycle.
    set_in(1, 1'b0, 1'b1, 8'h12, 16'hBEEF);
    tick();
    set_in(1, 1'b1, 1'b0, 8'h12, 16'h0000);
    tick();
    idle_ticks(4);

    // Lat 3: back-to-back reads, second issued in the rvalid cycle.
    set_in(2, 1'b1, 1'b0, 8'h00, 16'h0000);
    tick();
    tick();
    tick();
    set_in(2, 1'b1, 1'b0, 8'hFF, 16'h0000);
    tick();
    tick();
    tick();
    idle_ticks(3);

    // Lat 1: single-edge read.
    set_in(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    tick();
    idle_ticks(2);

    // Write coinciding with reset is dropped.
    rst_v[0] = 1'b1;
    set_in(0, 1'b0, 1'b1, 8'h40, 16'h7777);
    tick();
    idle_all();
    set_in(0, 1'b1, 1'b0, 8'h40, 16'h0000);
    tick();
    idle_ticks(2);

    // Conflicting strobes on every instance.
    for (int k = 0; k < N; k++) set_in(k, 1'b1, 1'b1, 8'h05, 16'hAAAA);
    tick();
    idle_ticks(1);
    for (int k = 0; k < N; k++) set_in(k, 1'b1, 1'b0, 8'h05, 16'h0000);
    tick();
    idle_ticks(5);

    // Lat 4: reset in the second WAIT cycle aborts the read.
    set_in(3, 1'b1, 1'b0, 8'h07, 16'h0000);
    tick();
    tick();
    rst_v[3] = 1'b1;
    tick();
    idle_ticks(5);
    set_in(3, 1'b1, 1'b0, 8'h07, 16'h0000);
    tick();
    idle_ticks(5);

    // Lat 4: write held high through WAIT is ignored.
    set_in(3, 1'b1, 1'b0, 8'h07, 16'h0000);
    tick();
    set_in(3, 1'b0, 1'b1, 8'h07, 16'h9999);
    tick();
    tick();
    tick();
    idle_ticks(2);
    set_in(3, 1'b1, 1'b0, 8'h07, 16'h0000);
    tick();
    idle_ticks(5);

    // Random traffic on the preloaded working set.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        set_in(k, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
               8'($urandom_range(0, 15)), 16'($urandom));
        rst_v[k] = ($urandom_range(0, 49) == 0);
      end
      tick();
    end
    idle_ticks(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
